// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch address sequencer.
// ROI/POI geometry, window size, FSM state type and the clamped window-base helper.
package fetch_pkg;

  localparam int ROI_DEPTH = 6;
  localparam int ROI_WIDTH = 6;
  localparam int POI_DEPTH = 4;
  localparam int POI_WIDTH = 4;

  localparam int WIN_ROWS = 32;
  localparam int WIN_COLS = 32;

  localparam int ROI_AW = ROI_DEPTH + ROI_WIDTH;
  localparam int POI_AW = POI_DEPTH + POI_WIDTH;
  localparam int ROW_W  = $clog2(WIN_ROWS);

  // POI grid pitch in ROI pixels, expressed as a shift
  localparam int STEP_ROW_SH = ROI_DEPTH - POI_DEPTH;
  localparam int STEP_COL_SH = ROI_WIDTH - POI_WIDTH;

  // Largest base that keeps a full window inside the ROI
  localparam int MAX_BASE_ROW = (2 ** ROI_DEPTH) - WIN_ROWS;
  localparam int MAX_BASE_COL = (2 ** ROI_WIDTH) - WIN_COLS;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef logic [ROI_AW-1:0] roi_addr_t;
  typedef logic [POI_AW-1:0] poi_addr_t;
  typedef logic [ROW_W-1:0]  win_row_t;

  typedef struct packed {
    logic [ROI_DEPTH-1:0] row;
    logic [ROI_WIDTH-1:0] col;
  } win_base_t;

  // Top-left corner of the window for POI p, clamped so the window never leaves the ROI
  function automatic win_base_t win_base(input poi_addr_t p);
    win_base_t b;
    int pr;
    int pc;
    int br;
    int bc;
    pr = int'(p[POI_AW-1:POI_WIDTH]);
    pc = int'(p[POI_WIDTH-1:0]);
    br = pr << STEP_ROW_SH;
    bc = pc << STEP_COL_SH;
    if (br > MAX_BASE_ROW) br = MAX_BASE_ROW;
    if (bc > MAX_BASE_COL) bc = MAX_BASE_COL;
    b.row = br[ROI_DEPTH-1:0];
    b.col = bc[ROI_WIDTH-1:0];
    return b;
  endfunction

endpackage

// File: rtl/fetch_seq_addr.sv
// Window-row address generator: clamped POI base plus row offset, flattened to a ROI address.
// Purely combinational so the write-back path can share it.
module fetch_seq_addr
  import fetch_pkg::*;
(
  input  logic [POI_AW-1:0] poi_i,
  input  logic [ROW_W-1:0]  row_i,
  output logic [ROI_AW-1:0] addr_o
);

  win_base_t            base;
  logic [ROI_DEPTH-1:0] row_sum;

  // base_row + row never overflows thanks to the clamp; since base_col < 2^ROI_WIDTH,
  // (row_sum * 2^ROI_WIDTH + base_col) is just the concatenation
  always_comb begin
    base    = win_base(poi_i);
    row_sum = base.row + ROI_DEPTH'(row_i);
    addr_o  = {row_sum, base.col};
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch-stage initiator: walks every POI in raster order and issues WIN_ROWS window-row
// reads per POI, with start/busy/done handshake, rdy stall and synchronous abort.
// Pipeline tags (out_valid/out_last_row/out_last_poi) trail the issue by one cycle.
// Build option FETCH_SEQ_SKIP_EDGE_EN: skip POIs whose unclamped window leaves the ROI.
//
// state | meaning
// IDLE  | waiting for start, counters cleared
// RUN   | issuing rows whenever rdy is high
// DRAIN | last fetch data returns this cycle
// DONE  | one-cycle done pulse, back to IDLE
module fetch_seq
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              rdy,
  output logic              en,
  output logic [ROI_AW-1:0] w_addr_re,
  output logic [POI_AW-1:0] POI_addr_re,
  output logic [ROW_W-1:0]  w_row,
  output logic              out_valid,
  output logic              out_last_row,
  output logic              out_last_poi,
  output logic              busy,
  output logic              done
);

`ifdef FETCH_SEQ_SKIP_EDGE_EN
  localparam int LAST_PR = MAX_BASE_ROW >> STEP_ROW_SH;
  localparam int LAST_PC = MAX_BASE_COL >> STEP_COL_SH;
  localparam poi_addr_t LAST_POI = poi_addr_t'(LAST_PR * (2 ** POI_WIDTH) + LAST_PC);

  // Only in-ROI POIs are ever visited, so stepping past the last valid column jumps to the next row
  function automatic poi_addr_t next_poi(input poi_addr_t p);
    poi_addr_t n;
    if (p == LAST_POI) begin
      n = '0;
    end else if (p[POI_WIDTH-1:0] == POI_WIDTH'(LAST_PC)) begin
      n = {p[POI_AW-1:POI_WIDTH] + 1'b1, {POI_WIDTH{1'b0}}};
    end else begin
      n = p + 1'b1;
    end
    return n;
  endfunction
`else
  localparam poi_addr_t LAST_POI = '1;

  function automatic poi_addr_t next_poi(input poi_addr_t p);
    return p + 1'b1;
  endfunction
`endif

  state_e    state_q, state_d;
  poi_addr_t poi_q, poi_d;
  win_row_t  row_q, row_d;
  logic      out_valid_q, out_last_row_q, out_last_poi_q;
  logic      last_row, last_issue;

  assign last_row   = (row_q == ROW_W'(WIN_ROWS - 1));
  assign last_issue = last_row && (poi_q == LAST_POI);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort takes priority everywhere, including over start in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !abort) state_d = RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (rdy && last_issue) state_d = DRAIN;
      DRAIN:   state_d = abort ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; en is combinational in rdy so a stalled cycle issues nothing
  always_comb begin
    en   = (state_q == RUN) && rdy;
    busy = (state_q != IDLE);
    done = (state_q == DONE) && !abort;
  end

  // Row/POI counters advance on issue, hold on stall, clear outside RUN or on abort
  always_comb begin
    poi_d = poi_q;
    row_d = row_q;
    if (abort || (state_q != RUN)) begin
      poi_d = '0;
      row_d = '0;
    end else if (en) begin
      if (last_row) begin
        row_d = '0;
        poi_d = next_poi(poi_q);
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  // Counters and pipeline tags, tags aligned with the fetch stage output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poi_q          <= '0;
      row_q          <= '0;
      out_valid_q    <= 1'b0;
      out_last_row_q <= 1'b0;
      out_last_poi_q <= 1'b0;
    end else begin
      poi_q          <= poi_d;
      row_q          <= row_d;
      out_valid_q    <= en;
      out_last_row_q <= en && last_row;
      out_last_poi_q <= en && last_issue;
    end
  end

  fetch_seq_addr u_addr (
    .poi_i  (poi_q),
    .row_i  (row_q),
    .addr_o (w_addr_re)
  );

  assign POI_addr_re  = poi_q;
  assign w_row        = row_q;
  assign out_valid    = out_valid_q;
  assign out_last_row = out_last_row_q;
  assign out_last_poi = out_last_poi_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: issue-count based reference model, per-cycle compare,
// directed full scan, stall, abort and mid-scan reset, plus randomized rdy/start traffic.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, rdy;
  logic        en, out_valid, out_last_row, out_last_poi, busy, done;
  logic [11:0] w_addr_re;
  logic [7:0]  POI_addr_re;
  logic [4:0]  w_row;

  always #5 clk = ~clk;

  fetch_seq dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .rdy          (rdy),
    .en           (en),
    .w_addr_re    (w_addr_re),
    .POI_addr_re  (POI_addr_re),
    .w_row        (w_row),
    .out_valid    (out_valid),
    .out_last_row (out_last_row),
    .out_last_poi (out_last_poi),
    .busy         (busy),
    .done         (done)
  );

`ifdef FETCH_SEQ_SKIP_EDGE_EN
  localparam int EXP_ISS = 2592;
`else
  localparam int EXP_ISS = 8192;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: list of visited POIs and a count of rows issued so far
  int vp[$];
  int n_iss;
  bit m_busy;
  int m_k;
  int m_tail;
  bit m_ov, m_olr, m_olp;
  bit chk_en;

  int en_cnt, done_cnt, olp_cnt, done_cyc;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit poi_ok(input int p);
`ifdef FETCH_SEQ_SKIP_EDGE_EN
    return ((p / 16) * 4 <= 32) && ((p % 16) * 4 <= 32);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int exp_addr(input int p, input int row);
    int br, bc;
    br = (p / 16) * 4;
    bc = (p % 16) * 4;
    if (br > 32) br = 32;
    if (bc > 32) bc = 32;
    return (br + row) * 64 + bc;
  endfunction

  function automatic bit m_run();
    return m_busy && (m_k < n_iss);
  endfunction

  function automatic int m_poi();
    return m_run() ? vp[m_k / 32] : 0;
  endfunction

  function automatic int m_row();
    return m_run() ? (m_k % 32) : 0;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_k = 0; m_tail = 0;
    m_ov = 0; m_olr = 0; m_olp = 0;
  endtask

  // Advance the model across one clock edge given the inputs held during the cycle
  task automatic m_step(input bit s, input bit a, input bit r);
    bit een;
    een   = m_run() && r;
    m_ov  = een;
    m_olr = een && ((m_k % 32) == 31);
    m_olp = een && (m_k == n_iss - 1);
    if (!m_busy) begin
      if (s && !a) begin m_busy = 1; m_k = 0; m_tail = 0; end
    end else if (a) begin
      m_busy = 0; m_k = 0; m_tail = 0;
    end else if (m_k < n_iss) begin
      if (r) begin
        m_k++;
        if (m_k == n_iss) m_tail = 1;
      end
    end else if (m_tail == 1) begin
      m_tail = 2;
    end else begin
      m_busy = 0; m_tail = 0;
    end
  endtask

  task automatic step(input bit s, input bit a, input bit r);
    start = s; abort = a; rdy = r;
    @(posedge clk);
    m_step(s, a, r);
    #1;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin : cmp
    bit een;
    int ep, er;
    if (chk_en) begin
      een = m_run() && rdy;
      ep  = m_poi();
      er  = m_row();
      chk("en", en, een);
      chk("POI_addr_re", POI_addr_re, ep);
      chk("w_row", w_row, er);
      chk("w_addr_re", w_addr_re, exp_addr(ep, er));
      chk("out_valid", out_valid, m_ov);
      chk("out_last_row", out_last_row, m_olr);
      chk("out_last_poi", out_last_poi, m_olp);
      chk("busy", busy, m_busy);
      chk("done", done, m_busy && (m_k == n_iss) && (m_tail == 2) && !abort);
      if (een && ep == 17 && er == 0) chk("addr poi17 row0", w_addr_re, 260);
      if (een && ep == 17 && er == 5) chk("addr poi17 row5", w_addr_re, 580);
      if (een && ep == 255 && er == 0) chk("addr poi255 row0", w_addr_re, 2080);
      if (een && ep == 255 && er == 31) chk("addr poi255 row31", w_addr_re, 4064);
      if (en) en_cnt++;
      if (out_last_poi) olp_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  initial begin
    int start_cyc, done_before;
    bit stalled;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; rdy = 1'b0;
    chk_en = 0; en_cnt = 0; done_cnt = 0; olp_cnt = 0; done_cyc = 0;
    m_reset();
    for (int p = 0; p < 256; p++) if (poi_ok(p)) vp.push_back(p);
    n_iss = vp.size() * 32;

    chk("model issue total", n_iss, EXP_ISS);
    chk("model addr poi17 row5", exp_addr(17, 5), 580);
`ifdef FETCH_SEQ_SKIP_EDGE_EN
    chk("model poi after 8", vp[9], 16);
    chk("model last poi", vp[vp.size() - 1], 136);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset en", en, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset w_addr_re", w_addr_re, 0);
    chk("reset POI", POI_addr_re, 0);
    chk("reset w_row", w_row, 0);
    reset_n = 1'b1;
    chk_en = 1;
    step(0, 0, 1);

    // Full scan, rdy held high
    en_cnt = 0; olp_cnt = 0; done_cnt = 0;
    start_cyc = cyc;
    step(1, 0, 1);
    for (int i = 0; i < 9000 && m_busy; i++) step(0, 0, 1);
    step(0, 0, 1);
    chk("scan A timeout", m_busy, 0);
    chk("scan A en pulses", en_cnt, EXP_ISS);
    chk("scan A done cycle", done_cyc - start_cyc, EXP_ISS + 2);
    chk("scan A done pulses", done_cnt, 1);
    chk("scan A last_poi pulses", olp_cnt, 1);
    chk("scan A busy after", busy, 0);

    // start with abort in IDLE stays idle
    step(1, 1, 1);
    chk("start+abort busy", busy, 0);
    step(0, 0, 1);

    // Random rdy, stall at POI 3 row 10, abort at POI 40
    stalled = 0;
    done_before = done_cnt;
    step(1, 0, 1);
    for (int i = 0; i < 20000 && m_busy; i++) begin
      if (m_poi() == 3 && m_row() == 10 && !stalled) begin
        stalled = 1;
        repeat (3) begin
          step(0, 0, 0);
          chk("stall POI", POI_addr_re, 3);
          chk("stall row", w_row, 10);
          chk("stall en", en, 0);
        end
      end else if (m_poi() == 40) begin
        step(0, 1, 1'($urandom_range(0, 1)));
        chk("abort busy", busy, 0);
        chk("abort POI clear", POI_addr_re, 0);
        break;
      end else begin
        step($urandom_range(0, 7) == 0, 0, $urandom_range(0, 3) != 0);
      end
    end
    chk("stall reached", stalled, 1);
    chk("abort returned idle", m_busy, 0);
    repeat (3) step(0, 0, 1);
    chk("abort no done", done_cnt, done_before);

    // Mid-scan reset, then a fresh scan to completion
    step(1, 0, 1);
    for (int i = 0; i < 500; i++) step(0, 0, $urandom_range(0, 3) != 0);
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("midreset en", en, 0);
    chk("midreset busy", busy, 0);
    chk("midreset out_valid", out_valid, 0);
    chk("midreset POI", POI_addr_re, 0);
    chk("midreset w_row", w_row, 0);
    chk("midreset w_addr_re", w_addr_re, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    reset_n = 1'b1;
    step(0, 0, 1);
    done_before = done_cnt;
    step(1, 0, 1);
    chk("restart POI", POI_addr_re, 0);
    chk("restart row", w_row, 0);
    chk("restart en", en, 1);
    for (int i = 0; i < 40000 && m_busy; i++)
      step($urandom_range(0, 15) == 0, 0, $urandom_range(0, 3) != 0);
    step(0, 0, 1);
    chk("scan D timeout", m_busy, 0);
    chk("scan D done pulses", done_cnt - done_before, 1);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
